// File: rtl/sha256_msg_pad_if.sv
// sha256_msg_pad_if: word-stream input and padded-block output bundle of the
// SHA-256 message padder. The master side feeds words and acknowledges blocks;
// the slave side is the padder itself.
interface sha256_msg_pad_if;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTES_W = 2;

    // Input word stream
    logic               s_valid_i;
    logic               s_ready_o;
    logic [WORD_W-1:0]  s_dat_msb_i;
    logic               s_last_i;
    logic [BYTES_W-1:0] s_bytes_i;

    // Padded block output towards the message schedule
    logic               dat_vaild_o;
    logic [WORD_W-1:0]  dat_msb_o;
    logic               blk_start_o;
    logic               blk_end_o;
    logic               blk_final_o;
    logic               blk_ack_i;
    logic               busy_o;

    modport master (
        output s_valid_i,
        output s_dat_msb_i,
        output s_last_i,
        output s_bytes_i,
        output blk_ack_i,
        input  s_ready_o,
        input  dat_vaild_o,
        input  dat_msb_o,
        input  blk_start_o,
        input  blk_end_o,
        input  blk_final_o,
        input  busy_o
    );

    modport slave (
        input  s_valid_i,
        input  s_dat_msb_i,
        input  s_last_i,
        input  s_bytes_i,
        input  blk_ack_i,
        output s_ready_o,
        output dat_vaild_o,
        output dat_msb_o,
        output blk_start_o,
        output blk_end_o,
        output blk_final_o,
        output busy_o
    );

endinterface

// File: rtl/sha256_msg_pad.sv
// sha256_msg_pad: SHA-256 message padder. Turns a big-endian word stream with
// an end-of-message marker into 16-word padded blocks (data, 0x80 marker,
// zero fill, 64-bit bit length) and holds after every block until the
// compression controller acknowledges it.
// Optional feature macro: SHA256_PAD_LEN64_EN -- when defined the bit-length
// counter is 64 bits wide; otherwise it is 32 bits, wraps modulo 2^32 and the
// upper length word is always zero.
module sha256_msg_pad (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    sha256_msg_pad_if.slave   bus
);

`ifdef SHA256_PAD_LEN64_EN
    localparam int unsigned LEN_W = 64;
`else
    localparam int unsigned LEN_W = 32;
`endif
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned INC_W  = 6;

    localparam logic [IDX_W-1:0]  IDX_LAST   = 4'd15;
    localparam logic [IDX_W-1:0]  IDX_LEN    = 4'd14;
    localparam logic [WORD_W-1:0] MARKER_WRD = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_DATA = 3'd0,
        ST_PAD  = 3'd1,
        ST_LENH = 3'd2,
        ST_LENL = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    state_t              state;
    state_t              resume;
    logic [IDX_W-1:0]    widx;
    logic                marker_pending;
    logic                final_blk;
    logic [LEN_W-1:0]    len;

    logic                vld_q;
    logic [WORD_W-1:0]   dat_q;
    logic                start_q;
    logic                end_q;
    logic                final_q;
    logic                busy_q;

    logic                ready_c;
    logic                hs_c;
    logic [WORD_W-1:0]   din_c;
    logic [INC_W-1:0]    inc_c;
    logic [WORD_W-1:0]   len_hi_c;
    state_t              data_nxt_c;

    // Input is accepted only while streaming data and out of reset/clear
    assign ready_c    = (state == ST_DATA) && rst_n && !clear;
    assign hs_c       = bus.s_valid_i && ready_c;
    assign data_nxt_c = bus.s_last_i ? ST_PAD : ST_DATA;

`ifdef SHA256_PAD_LEN64_EN
    assign len_hi_c = len[LEN_W-1:WORD_W];
`else
    assign len_hi_c = '0;
`endif

    // Last-word formatting: keep valid bytes, insert the 0x80 marker after them
    always_comb begin
        din_c = bus.s_dat_msb_i;
        if (bus.s_last_i) begin
            case (bus.s_bytes_i)
                2'd1:    din_c = {bus.s_dat_msb_i[31:24], 8'h80, 16'h0000};
                2'd2:    din_c = {bus.s_dat_msb_i[31:16], 8'h80, 8'h00};
                2'd3:    din_c = {bus.s_dat_msb_i[31:8], 8'h80};
                default: din_c = bus.s_dat_msb_i;
            endcase
        end
    end

    // Bit-length increment: full word, or 8 bits per valid byte on the last word
    always_comb begin
        inc_c = INC_W'(32);
        if (bus.s_last_i && (bus.s_bytes_i != 2'd0)) begin
            inc_c = {1'b0, bus.s_bytes_i, 3'b000};
        end
    end

    // Padder state machine with registered word/flag outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_DATA;
            resume         <= ST_DATA;
            widx           <= '0;
            marker_pending <= 1'b0;
            final_blk      <= 1'b0;
            len            <= '0;
            vld_q          <= 1'b0;
            dat_q          <= '0;
            start_q        <= 1'b0;
            end_q          <= 1'b0;
            final_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else if (clear) begin
            state          <= ST_DATA;
            resume         <= ST_DATA;
            widx           <= '0;
            marker_pending <= 1'b0;
            final_blk      <= 1'b0;
            len            <= '0;
            vld_q          <= 1'b0;
            dat_q          <= '0;
            start_q        <= 1'b0;
            end_q          <= 1'b0;
            final_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            vld_q   <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            final_q <= 1'b0;
            case (state)
                ST_DATA: begin
                    if (hs_c) begin
                        vld_q   <= 1'b1;
                        dat_q   <= din_c;
                        start_q <= (widx == '0);
                        end_q   <= (widx == IDX_LAST);
                        busy_q  <= 1'b1;
                        widx    <= widx + IDX_W'(1);
                        len     <= len + LEN_W'(inc_c);
                        if (bus.s_last_i) begin
                            marker_pending <= (bus.s_bytes_i == 2'd0);
                        end
                        if (widx == IDX_LAST) begin
                            state  <= ST_WAIT;
                            resume <= data_nxt_c;
                        end else begin
                            state  <= data_nxt_c;
                        end
                    end
                end
                ST_PAD: begin
                    if (marker_pending || (widx != IDX_LEN)) begin
                        vld_q          <= 1'b1;
                        dat_q          <= marker_pending ? MARKER_WRD : '0;
                        marker_pending <= 1'b0;
                        start_q        <= (widx == '0);
                        end_q          <= (widx == IDX_LAST);
                        widx           <= widx + IDX_W'(1);
                        if (widx == IDX_LAST) begin
                            state  <= ST_WAIT;
                            resume <= ST_PAD;
                        end
                    end else begin
                        state <= ST_LENH;
                    end
                end
                ST_LENH: begin
                    vld_q <= 1'b1;
                    dat_q <= len_hi_c;
                    widx  <= widx + IDX_W'(1);
                    state <= ST_LENL;
                end
                ST_LENL: begin
                    vld_q     <= 1'b1;
                    dat_q     <= len[WORD_W-1:0];
                    end_q     <= 1'b1;
                    final_q   <= 1'b1;
                    widx      <= '0;
                    final_blk <= 1'b1;
                    len       <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.blk_ack_i) begin
                        if (final_blk) begin
                            state     <= ST_DATA;
                            final_blk <= 1'b0;
                            busy_q    <= 1'b0;
                        end else begin
                            state     <= resume;
                        end
                    end
                end
                default: begin
                    state <= ST_DATA;
                end
            endcase
        end
    end

    // Output bundle
    assign bus.s_ready_o   = ready_c;
    assign bus.dat_vaild_o = vld_q;
    assign bus.dat_msb_o   = dat_q;
    assign bus.blk_start_o = start_q;
    assign bus.blk_end_o   = end_q;
    assign bus.blk_final_o = final_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_sha256_msg_pad.sv
// tb_sha256_msg_pad: directed and randomized checks of the SHA-256 padder
// against a byte-level padding model.
module tb_sha256_msg_pad;

    typedef struct {
        logic [31:0] w;
        logic        s;
        logic        e;
        logic        f;
        int          stamp;
    } cap_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  msg[$];
    logic [31:0] expq[$];
    cap_t        capq[$];
    int          ack_cyc[$];

    sha256_msg_pad_if bus();

    sha256_msg_pad dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter used to timestamp outputs and acks
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    always @(negedge clk) begin
        if (bus.dat_vaild_o === 1'b1) begin
            capq.push_back('{bus.dat_msb_o, bus.blk_start_o, bus.blk_end_o, bus.blk_final_o, cyc});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference padding: bytes, 0x80, zeros to 56 mod 64, 64-bit bit length
    task automatic build_exp();
        logic [7:0]  q[$];
        logic [63:0] bitlen;
        logic [31:0] w;
        q = msg;
        q.push_back(8'h80);
        while ((q.size() % 64) != 56) q.push_back(8'h00);
        bitlen = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) q.push_back(bitlen[8*i +: 8]);
        expq.delete();
        for (int i = 0; i < q.size(); i += 4) begin
            w = {q[i], q[i+1], q[i+2], q[i+3]};
            expq.push_back(w);
        end
    endtask

    task automatic rand_msg(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    task automatic drive_msg(input bit gaps);
        int          n;
        int          nw;
        int          t;
        logic [31:0] w;
        n  = msg.size();
        nw = (n + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++) begin
                if (4*i + b < n) w[31 - 8*b -: 8] = msg[4*i + b];
            end
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    bus.s_valid_i = 1'b0;
                end
            end
            @(negedge clk);
            bus.s_valid_i   = 1'b1;
            bus.s_dat_msb_i = w;
            bus.s_last_i    = (i == nw - 1);
            bus.s_bytes_i   = (i == nw - 1) ? 2'(n % 4) : 2'($urandom);
            t = 0;
            while (bus.s_ready_o !== 1'b1 && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 5000) begin
                chk("drive_timeout", 64'(t >= 5000), 64'd0);
                bus.s_valid_i = 1'b0;
                return;
            end
        end
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
    endtask

    task automatic do_acks(input int nblk, input bit gate);
        int t;
        int d;
        for (int k = 0; k < nblk; k++) begin
            t = 0;
            while (capq.size() < 16*(k+1) && t < 5000) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (t >= 5000) begin
                chk("block_timeout", 64'(t >= 5000), 64'd0);
                return;
            end
            chk("ready_low_at_word15", 64'(bus.s_ready_o), 64'd0);
            chk("busy_in_wait", 64'(bus.busy_o), 64'd1);
            d = gate ? 20 : int'($urandom_range(0, 4));
            for (int j = 0; j < d; j++) begin
                @(negedge clk);
                #1;
                if (gate) begin
                    chk($sformatf("gate_ready_%0d", j), 64'(bus.s_ready_o), 64'd0);
                    chk($sformatf("gate_valid_%0d", j), 64'(bus.dat_vaild_o), 64'd0);
                end
            end
            bus.blk_ack_i = 1'b1;
            ack_cyc.push_back(cyc);
            @(negedge clk);
            #1;
            bus.blk_ack_i = 1'b0;
            chk($sformatf("busy_after_ack_%0d", k), 64'(bus.busy_o), 64'(k != nblk - 1));
        end
    endtask

    task automatic run_msg(input bit gaps, input bit gate);
        int nblk;
        int nw;
        int idx;
        build_exp();
        nblk = expq.size() / 16;
        nw   = (msg.size() + 3) / 4;
        capq.delete();
        ack_cyc.delete();
        fork
            drive_msg(gaps);
            do_acks(nblk, gate);
        join
        repeat (4) @(negedge clk);
        #1;
        chk($sformatf("len%0d_count", msg.size()), 64'(capq.size()), 64'(expq.size()));
        for (int k = 0; k < expq.size() && k < capq.size(); k++) begin
            chk($sformatf("len%0d_word%0d", msg.size(), k), 64'(capq[k].w), 64'(expq[k]));
            chk($sformatf("len%0d_flags%0d", msg.size(), k),
                64'({capq[k].s, capq[k].e, capq[k].f}),
                64'({(k % 16) == 0, (k % 16) == 15, k == expq.size() - 1}));
        end
        for (int k = 1; k < nblk && k < ack_cyc.size() + 1; k++) begin
            idx = 16 * k;
            if (idx < capq.size()) begin
                if (idx >= nw)
                    chk($sformatf("len%0d_ack_lat%0d", msg.size(), k),
                        64'(capq[idx].stamp - ack_cyc[k-1]), 64'd2);
                else
                    chk($sformatf("len%0d_ack_min%0d", msg.size(), k),
                        64'(capq[idx].stamp - ack_cyc[k-1] >= 2), 64'd1);
            end
        end
    endtask

    task automatic check_abc(input string tag);
        chk({tag, "_w0"}, 64'(capq[0].w), 64'h6162_6380);
        for (int k = 1; k < 15; k++) chk($sformatf("%s_w%0d", tag, k), 64'(capq[k].w), 64'd0);
        chk({tag, "_w15"}, 64'(capq[15].w), 64'h18);
        chk({tag, "_start"}, 64'(capq[0].s), 64'd1);
        chk({tag, "_end_final"}, 64'({capq[15].e, capq[15].f}), 64'h3);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, 64'(bus.dat_vaild_o), 64'd0);
        chk({tag, "_data"},  64'(bus.dat_msb_o), 64'd0);
        chk({tag, "_flags"}, 64'({bus.blk_start_o, bus.blk_end_o, bus.blk_final_o}), 64'd0);
        chk({tag, "_busy"},  64'(bus.busy_o), 64'd0);
    endtask

    initial begin
        bus.s_valid_i   = 1'b0;
        bus.s_dat_msb_i = '0;
        bus.s_last_i    = 1'b0;
        bus.s_bytes_i   = '0;
        bus.blk_ack_i   = 1'b0;
        clear           = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_ready", 64'(bus.s_ready_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset_ready", 64'(bus.s_ready_o), 64'd1);

        // "abc": single block
        set_abc();
        run_msg(1'b0, 1'b0);
        check_abc("abc");

        // 55 bytes: marker in word 13, length fits in the same block
        rand_msg(55);
        run_msg(1'b1, 1'b0);
        chk("b55_w15", 64'(capq[15].w), 64'h1B8);
        chk("b55_w13_lo", 64'(capq[13].w[7:0]), 64'h80);

        // 56 bytes: marker at word 14 forces a second block
        rand_msg(56);
        run_msg(1'b1, 1'b0);
        chk("b56_w14", 64'(capq[14].w), 64'h8000_0000);
        chk("b56_w31", 64'(capq[31].w), 64'h1C0);

        // 64 bytes with ack held off for 20 cycles after each block
        rand_msg(64);
        run_msg(1'b0, 1'b1);
        chk("b64_blk1_final", 64'(capq[15].f), 64'd0);
        chk("b64_w16", 64'(capq[16].w), 64'h8000_0000);
        chk("b64_w31", 64'(capq[31].w), 64'h200);

        // Randomized lengths, including word-boundary corner cases
        rand_msg(59);
        run_msg(1'b1, 1'b0);
        rand_msg(63);
        run_msg(1'b1, 1'b0);
        for (int r = 0; r < 8; r++) begin
            rand_msg(int'($urandom_range(1, 200)));
            run_msg(1'($urandom), 1'b0);
        end

        // Asynchronous reset in the middle of a message
        capq.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.s_valid_i   = 1'b1;
            bus.s_dat_msb_i = $urandom;
            bus.s_last_i    = 1'b0;
        end
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        #1;
        chk("mid_words_seen", 64'(capq.size()), 64'd8);
        chk("mid_valid_before_rst", 64'(bus.dat_vaild_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        chk("mid_rst_ready", 64'(bus.s_ready_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_abc();
        run_msg(1'b0, 1'b0);
        check_abc("abc_after_rst");

        // Synchronous clear in the middle of a message
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.s_valid_i   = 1'b1;
            bus.s_dat_msb_i = $urandom;
            bus.s_last_i    = 1'b0;
        end
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        clear         = 1'b1;
        #1;
        chk("clear_ready", 64'(bus.s_ready_o), 64'd0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        check_idle_outputs("clear");
        chk("clear_ready_after", 64'(bus.s_ready_o), 64'd1);
        rand_msg(20);
        run_msg(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
